// File: rtl/cv32e40s_pkg.sv
// Shared LSU/OBI types and helpers for the data-side write buffer.
// Optional bypass of the write buffer is selected with CV32E40S_WBUF_BYPASS_EN.
package cv32e40s_pkg;

  localparam int unsigned WBUF_DEPTH_MAX = 4;

  // Write buffer states, derived from the occupancy count
  localparam logic [1:0] WBUF_EMPTY   = 2'd0;
  localparam logic [1:0] WBUF_PARTIAL = 2'd1;
  localparam logic [1:0] WBUF_FULL    = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
  } obi_data_req_t;

  function automatic logic is_bufferable_store(obi_data_req_t trans);
    return trans.we && trans.memtype[0];
  endfunction

endpackage

// File: rtl/cv32e40s_wbuf_fifo.sv
// Circular FIFO holding posted bufferable stores for the LSU write buffer.
module cv32e40s_wbuf_fifo
  import cv32e40s_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  obi_data_req_t        push_data,
  input  logic                 pop,
  output obi_data_req_t        head,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  obi_data_req_t        mem [DEPTH];
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wptr  <= '0;
      rptr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= next_ptr(wptr);
      end
      if (pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head = mem[rptr];
  assign cnt  = cnt_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == CNT_WIDTH'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (cnt_q == '0)));
`endif

endmodule

// File: rtl/cv32e40s_lsu_write_buffer.sv
// Posted-write buffer between the LSU response filter and the data OBI port.
// Define CV32E40S_WBUF_BYPASS_EN to let bufferable stores skip an empty buffer.
module cv32e40s_lsu_write_buffer
  import cv32e40s_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  obi_data_req_t        trans_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output obi_data_req_t        trans_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  if ((DEPTH < 1) || (DEPTH > WBUF_DEPTH_MAX)) begin : g_depth_check
    $error("cv32e40s_lsu_write_buffer: DEPTH out of range 1..4");
  end

  logic                 bufferable_i;
  logic                 push;
  logic                 pop;
  logic                 bypass;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  obi_data_req_t        head;

  cv32e40s_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (trans_i),
    .pop       (pop),
    .head      (head),
    .cnt       (cnt)
  );

  assign bufferable_i = valid_i && is_bufferable_store(trans_i);

  assign state = (cnt == '0)                  ? WBUF_EMPTY :
                 (cnt == CNT_WIDTH'(DEPTH))   ? WBUF_FULL  : WBUF_PARTIAL;

`ifdef CV32E40S_WBUF_BYPASS_EN
  // A store offered to an idle bus completes directly; otherwise it is queued
  assign bypass = bufferable_i && (state == WBUF_EMPTY) && ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (state != WBUF_EMPTY) && ready_i;
  // FULL blocks enqueue even when a dequeue happens in the same cycle
  assign push = bufferable_i && (state != WBUF_FULL) && !bypass;

  always_comb begin
    valid_o = 1'b0;
    trans_o = trans_i;
    if (state != WBUF_EMPTY) begin
      valid_o = 1'b1;
      trans_o = head;
    end else begin
`ifdef CV32E40S_WBUF_BYPASS_EN
      valid_o = valid_i;
`else
      valid_o = valid_i && !is_bufferable_store(trans_i);
`endif
    end
  end

  // Non-bufferable transfers wait for an empty buffer to keep bus order
  assign ready_o = is_bufferable_store(trans_i) ? (state != WBUF_FULL)
                                               : ((state == WBUF_EMPTY) && ready_i);

  assign busy_o = (state != WBUF_EMPTY) || valid_i;
  assign cnt_o  = cnt;

endmodule
